fetch_unit: RTL

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I pipeline. Owns the PC, issues word fetches over a valid/ready request channel to instruction memory, buffers in-order responses in a small FIFO, and drives the decode-stage instruction register. Consumes StallF/StallD/FlushD from the hazard unit and the taken-branch redirect (PCSrcE, PCTargetE) from Execute; discards responses belonging to a squashed path.

---
 rtl/fetch_unit_if.sv | 18 +
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between fetch_unit (master) and imem (slave).
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage and IF/ID register with credit-limited in-order fetch FIFO.
// Optional macro FETCH_BYPASS_EN: a live response may load decode directly when the FIFO is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         StallF,
    input  logic         StallD,
    input  logic         FlushD,
    input  logic         PCSrcE,
    input  logic [31:0]  PCTargetE,
    fetch_unit_if.master imem,
    output logic [31:0]  InstrD,
    output logic [31:0]  PCD,
    output logic [31:0]  PCPlus4D,
    output logic         ValidD
);

    localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]     NOP_INSTR  = 32'h0000_0013;
    localparam logic [AW+1:0]   CREDIT_MAX = (AW+2)'(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [31:0] pcf_r;
    logic [31:0] fifo_instr_r [DEPTH];
    logic [31:0] fifo_pc_r    [DEPTH];
    logic [31:0] tag_r        [DEPTH];
    ptr_t        fifo_rd_r, fifo_wr_r, tag_rd_r, tag_wr_r;
    cnt_t        count_r, outst_r, drop_r;
    logic [31:0] instr_d_r, pc_d_r, pcp4_d_r;
    logic        valid_d_r;

    logic [AW+1:0] credit_s;
    logic          req_valid_s, accept_s, rsp_live_s, kill_s, load_s;
    logic          pop_s, bypass_s, push_s;
    logic [31:0]   rsp_pc_s;
    cnt_t          outst_next_s;

    // Handshake, credit and FIFO/decode steering decisions for this cycle.
    always_comb begin
        credit_s     = {1'b0, count_r} + {1'b0, outst_r};
        req_valid_s  = !rst && !StallF && (credit_s < CREDIT_MAX);
        accept_s     = req_valid_s && imem.imem_req_ready;
        rsp_live_s   = imem.imem_rsp_valid && (drop_r == '0) && !PCSrcE;
        // A redirect also kills decode so no wrong-path word can become valid.
        kill_s       = FlushD || PCSrcE;
        load_s       = !StallD && !kill_s;
        pop_s        = load_s && (count_r != '0);
`ifdef FETCH_BYPASS_EN
        bypass_s     = load_s && (count_r == '0) && rsp_live_s;
`else
        bypass_s     = 1'b0;
`endif
        push_s       = rsp_live_s && !bypass_s;
        rsp_pc_s     = tag_r[tag_rd_r];
        outst_next_s = outst_r + cnt_t'(accept_s)
                     - cnt_t'(imem.imem_rsp_valid && (outst_r != '0));
    end

    assign imem.imem_req_valid = req_valid_s;
    assign imem.imem_req_addr  = pcf_r;
    assign InstrD              = instr_d_r;
    assign PCD                 = pc_d_r;
    assign PCPlus4D            = pcp4_d_r;
    assign ValidD              = valid_d_r;

    // PC, credit counters, drop counter and queue pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcf_r     <= RESET_PC;
            outst_r   <= '0;
            drop_r    <= '0;
            count_r   <= '0;
            fifo_rd_r <= '0;
            fifo_wr_r <= '0;
            tag_rd_r  <= '0;
            tag_wr_r  <= '0;
        end else begin
            outst_r <= outst_next_s;
            if (PCSrcE) begin
                pcf_r     <= PCTargetE;
                drop_r    <= outst_next_s;
                count_r   <= '0;
                fifo_rd_r <= '0;
                fifo_wr_r <= '0;
                tag_rd_r  <= '0;
                tag_wr_r  <= '0;
            end else begin
                if (accept_s) begin
                    pcf_r    <= pcf_r + 32'd4;
                    tag_wr_r <= tag_wr_r + ptr_t'(1'b1);
                end
                if (imem.imem_rsp_valid && (drop_r != '0)) begin
                    drop_r <= drop_r - cnt_t'(1'b1);
                end
                if (rsp_live_s) begin
                    tag_rd_r <= tag_rd_r + ptr_t'(1'b1);
                end
                if (push_s) begin
                    fifo_wr_r <= fifo_wr_r + ptr_t'(1'b1);
                end
                if (pop_s) begin
                    fifo_rd_r <= fifo_rd_r + ptr_t'(1'b1);
                end
                count_r <= count_r + cnt_t'(push_s) - cnt_t'(pop_s);
            end
        end
    end

    // Instruction FIFO and PC-tag queue storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr_r[i] <= 32'h0000_0000;
                fifo_pc_r[i]    <= 32'h0000_0000;
                tag_r[i]        <= 32'h0000_0000;
            end
        end else begin
            if (push_s) begin
                fifo_instr_r[fifo_wr_r] <= imem.imem_rsp_data;
                fifo_pc_r[fifo_wr_r]    <= rsp_pc_s;
            end
            if (accept_s && !PCSrcE) begin
                tag_r[tag_wr_r] <= pcf_r;
            end
        end
    end

    // IF/ID decode register.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_d_r <= NOP_INSTR;
            pc_d_r    <= 32'h0000_0000;
            pcp4_d_r  <= 32'h0000_0000;
            valid_d_r <= 1'b0;
        end else if (kill_s) begin
            instr_d_r <= NOP_INSTR;
            valid_d_r <= 1'b0;
        end else if (load_s) begin
            if (pop_s) begin
                instr_d_r <= fifo_instr_r[fifo_rd_r];
                pc_d_r    <= fifo_pc_r[fifo_rd_r];
                pcp4_d_r  <= fifo_pc_r[fifo_rd_r] + 32'd4;
                valid_d_r <= 1'b1;
            end else if (bypass_s) begin
                instr_d_r <= imem.imem_rsp_data;
                pc_d_r    <= rsp_pc_s;
                pcp4_d_r  <= rsp_pc_s + 32'd4;
                valid_d_r <= 1'b1;
            end else begin
                instr_d_r <= NOP_INSTR;
                valid_d_r <= 1'b0;
            end
        end
    end

    // Memory must never answer when nothing is outstanding.
    always @(posedge clk) begin
        if (!rst && imem.imem_rsp_valid) begin
            assert (outst_r != '0)
                else $error("fetch_unit: response with no request outstanding");
        end
    end

endmodule
